dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences data-memory accesses for the instruction held in the EX/MEM pipeline register.
- Watches the MemRead/MemWrite outputs of EX/MEM and issues a req/ack transaction to a variable-latency data memory.
- Drives stall_o back into the EX/MEM register (and the upstream stages) until the access completes.
- Bounds every access with a timeout watchdog, so a non-responding memory cannot hang the pipeline.

Parameters:
- ADDR_W, 32, memory address width
- DATA_W, 32, memory data width
- TIMEOUT_CYC, 16, maximum ACCESS-state cycles waiting for mem_ack_i before aborting (must be >= 1)

Ports:
- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  synchronous, active-low reset
- MemRead_i  in  1  MemRead from EX/MEM
- MemWrite_i  in  1  MemWrite from EX/MEM
- addr_i  in  ADDR_W  ALU result from EX/MEM (effective address)
- wdata_i  in  DATA_W  store data from EX/MEM
- stall_o  out  1  hold EX/MEM and the earlier pipeline registers
- rdata_o  out  DATA_W  load data for the MEM/WB register
- err_o  out  1  one-cycle pulse: access aborted by timeout or illegal command
- busy_o  out  1  high when state != IDLE
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write, 0 = read
- mem_addr_o  out  ADDR_W  latched address
- mem_wdata_o  out  DATA_W  latched write data
- mem_ack_i  in  1  memory completion; sampled only while mem_req_o = 1
- mem_rdata_i  in  DATA_W  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_i = 0 at a rising edge):
  - state becomes IDLE; counter cleared.
  - mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, rdata_o = 0, err_o = 0, busy_o = 0.
  - stall_o is 0 while rst_i = 0.
  - Reset mid-ACCESS abandons the transaction; mem_req_o drops at that edge and a late ack is ignored.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - cmd = MemRead_i | MemWrite_i.
  - stall_o = cmd, combinationally in the same cycle, so EX/MEM holds at the next edge.
  - If cmd: at the edge, latch addr_i/wdata_i into mem_addr_o/mem_wdata_o, set mem_we_o = MemWrite_i, set mem_req_o = 1, clear the counter, go to ACCESS.
  - MemRead_i and MemWrite_i both high: treated as a write, and err_o pulses in the first ACCESS cycle.
- ACCESS:
  - stall_o = 1, mem_req_o = 1; the latched address, data and we are stable.
  - If mem_ack_i: at the edge, mem_req_o = 0; rdata_o = mem_rdata_i for a read, rdata_o unchanged for a write; go to DONE.
  - Otherwise the counter increments. When the counter = TIMEOUT_CYC-1 with no ack: at the edge, mem_req_o = 0, rdata_o = 0, err_o = 1 for the DONE cycle, go to DONE.
  - An ack in the final allowed cycle wins over the timeout.
- DONE:
  - Exactly one cycle, stall_o = 0, so the pipeline advances and MEM/WB captures rdata_o.
  - Always returns to IDLE, regardless of inputs. The same instruction is still visible on the inputs during DONE, so re-triggering there is forbidden.
  - Back-to-back memory instructions: the next one is detected in the following IDLE cycle.
- Latency:
  - Ack in the first ACCESS cycle gives 2 stall cycles (IDLE-detect + ACCESS) followed by DONE.
  - In general, stall cycles = 1 + (ACCESS cycles until ack).
- mem_ack_i while in IDLE or DONE is ignored.
- err_o is registered and is never high outside DONE or the first ACCESS cycle of an illegal command.
- Counter width = clog2(TIMEOUT_CYC+1).

Decomposition:
- Shared package dmem_ctrl_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - 2-bit command encoding matching the EX/MEM M field (bit0 = MemRead, bit1 = MemWrite)
  - default TIMEOUT_CYC constant
- One sub-module, dmem_timeout_cnt:
  - clear/enable counter with an "expire" output, parameterised by TIMEOUT_CYC.
- The FSM and output registers stay in dmem_access_ctrl.

Test Plan:
- Reset: hold rst_i = 0 for 2 cycles with MemRead_i = 1 -> stall_o = 0, mem_req_o = 0, rdata_o = 0, busy_o = 0; release -> stall_o = 1 in the same cycle, mem_req_o = 1 next edge.
- Single load: addr_i = 0x40, memory acks in 1st ACCESS cycle with rdata 0xDEADBEEF -> stall_o high for exactly 2 cycles, DONE cycle has stall_o = 0 and rdata_o = 0xDEADBEEF, mem_addr_o = 0x40.
- Store with 3-cycle memory: MemWrite_i = 1, wdata_i = 0x1234, ack on 3rd ACCESS cycle -> mem_we_o = 1, mem_wdata_o = 0x1234 stable for all 3 cycles, 4 stall cycles, rdata_o unchanged, no re-request during DONE.
- Timeout with TIMEOUT_CYC = 4 and memory never acking -> mem_req_o high exactly 4 cycles, then DONE with err_o = 1, rdata_o = 0; ack on cycle 4 instead -> no err_o.
- Back-to-back loads, plus illegal MemRead = MemWrite = 1 -> second access starts in the IDLE cycle after DONE; the illegal command performs a write and pulses err_o in the first ACCESS cycle.
- Reset asserted in 2nd ACCESS cycle -> next edge: IDLE, mem_req_o = 0; ack arriving afterwards has no effect.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ctrl_pkg
//  Description : Shared types and constants for the data-memory access
//                controller: FSM state encoding, the EX/MEM "M" command
//                field encoding and the default timeout depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_ctrl_pkg;

    // Controller states. Width is fixed so the encoding is stable in netlists.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Command as carried in the EX/MEM M field: bit0 = MemRead, bit1 = MemWrite.
    typedef logic [1:0] mem_cmd_t;

    localparam int       c_CMD_READ_BIT  = 0;
    localparam int       c_CMD_WRITE_BIT = 1;
    localparam mem_cmd_t c_CMD_NONE      = 2'b00;
    localparam mem_cmd_t c_CMD_ILLEGAL   = 2'b11;

    // Default number of ACCESS cycles to wait for an acknowledge.
    localparam int c_DEFAULT_TIMEOUT_CYC = 16;

endpackage : dmem_ctrl_pkg
`default_nettype wire

// File: rtl/dmem_timeout_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_timeout_cnt
//  Description : Clear/enable watchdog counter. o_expire is high while the
//                count sits at TIMEOUT_CYC-1, i.e. during the last ACCESS
//                cycle the controller is allowed to wait for an acknowledge.
//  Ports       : clk_i     - clock, rising edge
//                rst_i     - synchronous active-low reset
//                i_clear   - force count to zero (has priority over enable)
//                i_enable  - advance the count by one
//                o_expire  - count has reached its final allowed value
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_timeout_cnt
    import dmem_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = c_DEFAULT_TIMEOUT_CYC
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_LAST);
    assign o_expire  = w_at_last;

    // The count saturates at its final value; the controller always leaves
    // ACCESS once expire is seen, so saturation only guards against wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : dmem_timeout_cnt
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_access_ctrl
//  Description : Sequences the data-memory access of the instruction held in
//                EX/MEM. A MemRead/MemWrite command raises stall_o in the same
//                cycle, launches a req/ack transaction to a variable-latency
//                memory and keeps the pipeline stalled until the memory acks
//                or the watchdog expires. A single DONE cycle then releases
//                the pipeline so MEM/WB can capture rdata_o.
//  Ports       : clk_i, rst_i (sync, active-low)
//                MemRead_i, MemWrite_i, addr_i, wdata_i   - from EX/MEM
//                stall_o, rdata_o, err_o, busy_o           - to the pipeline
//                mem_req_o, mem_we_o, mem_addr_o,
//                mem_wdata_o, mem_ack_i, mem_rdata_i       - memory interface
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = c_DEFAULT_TIMEOUT_CYC
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // EX/MEM side
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    // Pipeline control / MEM/WB side
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic              busy_o,
    // Memory side
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_next_state;

    mem_cmd_t          w_cmd;
    logic              w_cmd_valid;
    logic              w_cmd_illegal;
    logic              w_ack;
    logic              w_expire;
    logic              w_in_access;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    assign w_cmd         = {MemWrite_i, MemRead_i};
    assign w_cmd_valid   = (w_cmd != c_CMD_NONE);
    assign w_cmd_illegal = (w_cmd == c_CMD_ILLEGAL);
    assign w_in_access   = (r_state == ST_ACCESS);

    // The acknowledge is only meaningful while a request is outstanding;
    // stray acks in IDLE or DONE are masked here.
    assign w_ack = mem_ack_i & r_mem_req;

    // ------------------------------------------------------------------
    // Watchdog: counts ACCESS cycles without an acknowledge. It is held
    // clear outside ACCESS so each access starts from zero.
    // ------------------------------------------------------------------
    dmem_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_clear  (!w_in_access),
        .i_enable (w_in_access && !w_ack),
        .o_expire (w_expire)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_cmd_valid) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // An ack in the final allowed cycle is a normal completion;
                // both paths lead to DONE, only the datapath differs.
                if (w_ack || w_expire) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                // The completed instruction is still on the inputs here,
                // so the command is deliberately not looked at.
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        stall_o = 1'b0;
        busy_o  = (r_state != ST_IDLE);
        unique case (r_state)
            ST_IDLE:   stall_o = w_cmd_valid;
            ST_ACCESS: stall_o = 1'b1;
            ST_DONE:   stall_o = 1'b0;
            default:   stall_o = 1'b0;
        endcase
        // The pipeline must never be frozen while it is being reset.
        if (!rst_i) begin
            stall_o = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Memory interface and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            // err is a single-cycle pulse unless re-armed below.
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_cmd_valid) begin
                        r_mem_req   <= 1'b1;
                        // Read+write together is carried out as a write.
                        r_mem_we    <= w_cmd[c_CMD_WRITE_BIT];
                        r_mem_addr  <= addr_i;
                        r_mem_wdata <= wdata_i;
                        r_err       <= w_cmd_illegal;
                    end
                end
                ST_ACCESS: begin
                    if (w_ack) begin
                        r_mem_req <= 1'b0;
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata_i;
                        end
                    end else if (w_expire) begin
                        r_mem_req <= 1'b0;
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Read-side bit of the command only matters through w_cmd_valid.
    logic w_unused_read_bit;
    assign w_unused_read_bit = w_cmd[c_CMD_READ_BIT];

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;

endmodule : dmem_access_ctrl
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_access_ctrl
//  Description : Self-checking bench for dmem_access_ctrl (TIMEOUT_CYC = 4).
//                Stimulus pushes hand-computed expected transactions into a
//                scoreboard queue; a monitor pops one per DONE cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, err_o, busy_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    always #5 clk_i = ~clk_i;

    dmem_access_ctrl #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Memory responder: acks in the mem_lat-th request cycle (0 = never)
    // ------------------------------------------------------------------
    int          mem_lat   = 1;
    logic [31:0] mem_data  = '0;
    logic        force_ack = 1'b0;
    int          mcnt      = 0;

    always @(negedge clk_i) begin
        if (force_ack) begin
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'hFFFF_FFFF;
        end else if (!rst_i || !mem_req_o) begin
            mcnt        = 0;
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
        end else begin
            mcnt++;
            mem_ack_i   = (mem_lat != 0) && (mcnt == mem_lat);
            mem_rdata_i = mem_ack_i ? mem_data : 32'hBAD0_BAD0;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard and monitor
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err_first;
        logic        err_done;
        int          stall;
        int          req;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    logic        unstable  = 1'b0;
    logic [31:0] cap_addr, cap_wdata;
    logic        cap_we, cap_err_first;
    logic        in_done;

    always @(negedge clk_i) begin
        if (!rst_i) begin
            stall_cnt = 0;
            req_cnt   = 0;
            unstable  = 1'b0;
        end else begin
            in_done = busy_o && !stall_o;
            if (mem_req_o) begin
                req_cnt++;
                if (req_cnt == 1) begin
                    cap_addr      = mem_addr_o;
                    cap_we        = mem_we_o;
                    cap_wdata     = mem_wdata_o;
                    cap_err_first = err_o;
                end else if (mem_addr_o !== cap_addr || mem_we_o !== cap_we ||
                             mem_wdata_o !== cap_wdata) begin
                    unstable = 1'b1;
                end
            end
            if (stall_o) stall_cnt++;
            if (err_o && !in_done && !(mem_req_o && req_cnt == 1))
                chk("err_outside_window", {31'b0, err_o}, 32'd0);
            if (in_done) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got DONE at addr 0x%08h, expected none", cap_addr);
                end else begin
                    e = sb_q.pop_front();
                    chk("stall_cycles", 32'(stall_cnt), 32'(e.stall));
                    chk("req_cycles",   32'(req_cnt),   32'(e.req));
                    chk("mem_addr",     cap_addr,       e.addr);
                    chk("mem_we",       {31'b0, cap_we}, {31'b0, e.we});
                    chk("mem_wdata",    cap_wdata,      e.wdata);
                    chk("req_stable",   {31'b0, unstable}, 32'd0);
                    chk("err_first",    {31'b0, cap_err_first}, {31'b0, e.err_first});
                    chk("err_done",     {31'b0, err_o}, {31'b0, e.err_done});
                    chk("rdata_done",   rdata_o,        e.rdata);
                    chk("req_in_done",  {31'b0, mem_req_o}, 32'd0);
                end
                stall_cnt = 0;
                req_cnt   = 0;
                unstable  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_exp(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [31:0] rd, input logic ef, input logic ed,
                            input int st, input int rq);
        exp_t x;
        x.addr = a; x.we = we; x.wdata = wd; x.rdata = rd;
        x.err_first = ef; x.err_done = ed; x.stall = st; x.req = rq;
        sb_q.push_back(x);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (busy_o && !stall_o) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE within 40 cycles, expected DONE");
        end
    endtask

    // Called at posedge+1; applies one instruction until its DONE cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int lat, input logic [31:0] md);
        mem_lat = lat; mem_data = md;
        MemRead_i = rd; MemWrite_i = wr; addr_i = a; wdata_i = wd;
        @(negedge clk_i);
        chk("stall_on_detect", {31'b0, stall_o}, 32'd1);
        wait_done();
        @(posedge clk_i); #1;
        MemRead_i = 1'b0; MemWrite_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst_i = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
        addr_i = 32'h10; wdata_i = 32'h0;
        mem_lat = 1; mem_data = 32'h0000_1111;

        // Reset held with a pending load
        push_exp(32'h10, 1'b0, 32'h0, 32'h0000_1111, 1'b0, 1'b0, 2, 1);
        @(posedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        chk("rst_req",   {31'b0, mem_req_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_busy",  {31'b0, busy_o}, 32'd0);
        chk("rst_err",   {31'b0, err_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("release_stall", {31'b0, stall_o}, 32'd1);
        chk("release_req",   {31'b0, mem_req_o}, 32'd0);
        @(negedge clk_i);
        chk("release_req_next", {31'b0, mem_req_o}, 32'd1);
        wait_done();
        @(posedge clk_i); #1;
        MemRead_i = 1'b0;

        // Single load, ack in first ACCESS cycle
        push_exp(32'h40, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 1);
        issue(1'b1, 1'b0, 32'h40, 32'h0, 1, 32'hDEAD_BEEF);

        // Store, ack in third ACCESS cycle; rdata keeps previous load value
        push_exp(32'h80, 1'b1, 32'h1234, 32'hDEAD_BEEF, 1'b0, 1'b0, 4, 3);
        issue(1'b0, 1'b1, 32'h80, 32'h1234, 3, 32'h5555_5555);
        @(negedge clk_i);
        chk("no_retrigger_req",  {31'b0, mem_req_o}, 32'd0);
        chk("no_retrigger_busy", {31'b0, busy_o}, 32'd0);
        @(posedge clk_i); #1;

        // Timeout: memory never acks
        push_exp(32'hC0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5, 4);
        issue(1'b1, 1'b0, 32'hC0, 32'h0, 0, 32'h0);
        @(posedge clk_i); #1;

        // Ack in the last allowed cycle wins over timeout
        push_exp(32'hC4, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0, 5, 4);
        issue(1'b1, 1'b0, 32'hC4, 32'h0, 4, 32'hCAFE_F00D);

        // Back-to-back loads, then an illegal read+write command
        push_exp(32'h100, 1'b0, 32'h0,  32'hA5A5_A5A5, 1'b0, 1'b0, 2, 1);
        push_exp(32'h104, 1'b0, 32'h0,  32'h5A5A_5A5A, 1'b0, 1'b0, 3, 2);
        push_exp(32'h200, 1'b1, 32'h77, 32'h5A5A_5A5A, 1'b1, 1'b0, 2, 1);
        issue(1'b1, 1'b0, 32'h100, 32'h0,  1, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 32'h104, 32'h0,  2, 32'h5A5A_5A5A);
        issue(1'b1, 1'b1, 32'h200, 32'h77, 1, 32'h9999_9999);
        @(posedge clk_i); #1;

        // Reset during second ACCESS cycle, then a late ack
        mem_lat = 3; mem_data = 32'h3333_3333;
        MemRead_i = 1'b1; addr_i = 32'h300; wdata_i = 32'h0;
        @(negedge clk_i);
        chk("abort_stall_detect", {31'b0, stall_o}, 32'd1);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("abort_stall_in_rst", {31'b0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        MemRead_i = 1'b0;
        rst_i     = 1'b1;
        force_ack = 1'b1;
        @(negedge clk_i);
        chk("abort_req",  {31'b0, mem_req_o}, 32'd0);
        chk("abort_busy", {31'b0, busy_o}, 32'd0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("late_ack_busy",  {31'b0, busy_o}, 32'd0);
        chk("late_ack_req",   {31'b0, mem_req_o}, 32'd0);
        chk("late_ack_rdata", rdata_o, 32'd0);
        chk("late_ack_err",   {31'b0, err_o}, 32'd0);
        chk("late_ack_stall", {31'b0, stall_o}, 32'd0);
        force_ack = 1'b0;
        @(posedge clk_i); #1;

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dmem_access_ctrl
`default_nettype wire
